// File: rtl/chunked_copy_engine_if.sv
// ============================================================================
// Module   : chunked_copy_engine_if
// Brief    : Handshake/data bundle for chunked_copy_engine (s_par present when
//            CHUNK_PARITY_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface chunked_copy_engine_if #(
  parameter int W     = 256,
  parameter int CHUNK = 8
);
  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          busy;
  logic [CW-1:0] chunk_idx;
`ifdef CHUNK_PARITY_EN
  logic [NCHUNK-1:0] s_par;
`endif

  modport master (
    output in_valid, a, flush, out_ready,
`ifdef CHUNK_PARITY_EN
    input  s_par,
`endif
    input  in_ready, out_valid, s, busy, chunk_idx
  );

  modport slave (
    input  in_valid, a, flush, out_ready,
`ifdef CHUNK_PARITY_EN
    output s_par,
`endif
    output in_ready, out_valid, s, busy, chunk_idx
  );
endinterface

`default_nettype wire

// File: rtl/chunked_copy_engine.sv
// ============================================================================
// Module   : chunked_copy_engine
// Brief    : Copies a W-bit word CHUNK bits per clock between valid/ready
//            handshakes. Optional per-chunk parity output: CHUNK_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chunked_copy_engine #(
  parameter int W     = 256,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  chunked_copy_engine_if.slave  bus
);
  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] c_last_idx = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_src;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_s;
  logic [W-1:0]  w_work_next;
  logic [CW-1:0] r_idx;
  logic          r_out_valid;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_last;

  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
  assign w_last     = (r_state == COPY) && (r_idx == c_last_idx);

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_next = COPY;
        COPY:    if (w_last)   w_state_next = DONE;
        DONE: begin
          if (w_accept)           w_state_next = COPY;
          else if (bus.out_ready) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Merge the current chunk so the final chunk lands in s on the same edge.
  always_comb begin
    w_work_next = r_work;
    w_work_next[int'(r_idx)*CHUNK +: CHUNK] = r_src[int'(r_idx)*CHUNK +: CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_work      <= '0;
      r_s         <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (bus.flush) begin
        r_idx       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_accept) begin
          r_src       <= bus.a;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
        end else if ((r_state == DONE) && bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (r_state == COPY) begin
          r_work <= w_work_next;
          if (w_last) begin
            r_s         <= w_work_next;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
      end
    end
  end

`ifdef CHUNK_PARITY_EN
  logic [NCHUNK-1:0] r_par_work;
  logic [NCHUNK-1:0] r_s_par;
  logic [NCHUNK-1:0] w_par_next;

  always_comb begin
    w_par_next = r_par_work;
    w_par_next[r_idx] = ^r_src[int'(r_idx)*CHUNK +: CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_work <= '0;
      r_s_par    <= '0;
    end else if (!bus.flush && (r_state == COPY)) begin
      r_par_work <= w_par_next;
      if (w_last) r_s_par <= w_par_next;
    end
  end

  assign bus.s_par = r_s_par;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.s         = r_s;
  assign bus.busy      = (r_state == COPY);
  assign bus.chunk_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_chunked_copy_engine.sv
// ============================================================================
// Module   : tb_chunked_copy_engine
// Brief    : Directed self-checking bench with an expected-word scoreboard;
//            parity checks active when CHUNK_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_chunked_copy_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chunked_copy_engine_if #(.W(256), .CHUNK(8)) m ();
  chunked_copy_engine_if #(.W(16),  .CHUNK(4)) q ();
  chunked_copy_engine_if #(.W(8),   .CHUNK(8)) u ();

  chunked_copy_engine #(.W(256), .CHUNK(8)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m.slave));
  chunked_copy_engine #(.W(16),  .CHUNK(4)) dut_q (.clk(clk), .rst_n(rst_n), .bus(q.slave));
  chunked_copy_engine #(.W(8),   .CHUNK(8)) dut_u (.clk(clk), .rst_n(rst_n), .bus(u.slave));

  int n_checks = 0;
  int n_err    = 0;
  logic [255:0] exp_q[$];
  logic [255:0] exp_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the sample point after acceptance until out_valid is seen.
  task automatic wait_m(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (m.out_valid !== 1'b1 && cyc < 100) begin
      if (m.busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 256'd1, 256'd0);
    end else begin
      exp_w = exp_q.pop_front();
      chk(tag, m.s, exp_w);
    end
  endtask

  initial begin
    int cyc, bcnt, guard;
    logic [255:0] p1, p2, p3, p5, p6;
    p1 = {4{64'h0123456789ABCDEF}};
    p2 = {8{32'hDEADBEEF}} ^ {64'h1, 64'h2, 64'h4, 64'h8};
    p3 = {16{16'h5A3C}};
    p5 = {32{8'hC3}};
    p6 = {2{128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0}};

    rst_n = 1'b0;
    m.in_valid = 1'b0; m.a = '0; m.flush = 1'b0; m.out_ready = 1'b0;
    q.in_valid = 1'b0; q.a = '0; q.flush = 1'b0; q.out_ready = 1'b0;
    u.in_valid = 1'b0; u.a = '0; u.flush = 1'b0; u.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  256'(m.in_ready),  256'd1);
    chk("rst_out_valid", 256'(m.out_valid), 256'd0);
    chk("rst_s",         m.s,               256'd0);

    // Basic copy with latency and busy length
    m.a = p1; m.in_valid = 1'b1; m.out_ready = 1'b1;
    tick();
    m.in_valid = 1'b0;
    exp_q.push_back(p1);
    chk("acc_busy", 256'(m.busy), 256'd1);
    chk("acc_idx",  256'(m.chunk_idx), 256'd0);
    wait_m(cyc, bcnt);
    chk("basic_latency", 256'(cyc), 256'd32);
    chk("basic_busy_cycles", 256'(bcnt), 256'd32);
    pop_chk("basic_s");
    tick();
    chk("basic_ov_drop", 256'(m.out_valid), 256'd0);
    chk("basic_idle_ready", 256'(m.in_ready), 256'd1);
    chk("basic_s_hold", m.s, p1);

    // Back-pressure, then back-to-back accept in DONE
    m.out_ready = 1'b0; m.a = p2; m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    exp_q.push_back(p2);
    wait_m(cyc, bcnt);
    chk("bp_latency", 256'(cyc), 256'd32);
    pop_chk("bp_s");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ov_hold", 256'(m.out_valid), 256'd1);
      chk("bp_s_hold",  m.s, p2);
      chk("bp_in_ready", 256'(m.in_ready), 256'd0);
    end
    m.a = ~p2; m.in_valid = 1'b1; m.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 256'(m.in_ready), 256'd1);
    tick();
    m.in_valid = 1'b0;
    exp_q.push_back(~p2);
    chk("b2b_busy", 256'(m.busy), 256'd1);
    chk("b2b_ov_low", 256'(m.out_valid), 256'd0);
    chk("b2b_s_prev", m.s, p2);
    wait_m(cyc, bcnt);
    chk("b2b_latency", 256'(cyc), 256'd32);
    pop_chk("b2b_s");
    tick();

    // in_valid during COPY is ignored
    m.a = p3; m.in_valid = 1'b1;
    tick();
    exp_q.push_back(p3);
    m.a = ~p3;
    for (int i = 0; i < 20; i++) begin
      chk("copy_in_ready", 256'(m.in_ready), 256'd0);
      tick();
    end
    m.in_valid = 1'b0;
    guard = 0;
    while (m.out_valid !== 1'b1 && guard < 50) begin tick(); guard++; end
    chk("ign_timeout", 256'(guard < 50), 256'd1);
    pop_chk("ign_s");
    tick();

    // Flush at chunk 17
    m.a = p5; m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    guard = 0;
    while (m.chunk_idx !== 5'd17 && guard < 50) begin tick(); guard++; end
    chk("fl_reach17", 256'(m.chunk_idx), 256'd17);
    m.flush = 1'b1; m.a = p6; m.in_valid = 1'b1;
    tick();
    chk("fl_busy", 256'(m.busy), 256'd0);
    chk("fl_ov", 256'(m.out_valid), 256'd0);
    chk("fl_idx", 256'(m.chunk_idx), 256'd0);
    chk("fl_s_keep", m.s, p3);
    tick();
    chk("fl_idle_no_accept", 256'(m.busy), 256'd0);
    m.flush = 1'b0;
    tick();
    exp_q.push_back(p6);
    chk("fl_fresh_busy", 256'(m.busy), 256'd1);
    m.in_valid = 1'b0;
    wait_m(cyc, bcnt);
    chk("fl_fresh_latency", 256'(cyc), 256'd32);
    pop_chk("fl_fresh_s");
    tick();

    // Narrow instance: 16-bit word in 4-bit chunks
    q.a = 16'hF731; q.in_valid = 1'b1; q.out_ready = 1'b0;
    tick();
    q.in_valid = 1'b0;
    cyc = 0;
    while (q.out_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("q_latency", 256'(cyc), 256'd4);
    chk("q_s", 256'(q.s), 256'h F731);
`ifdef CHUNK_PARITY_EN
    chk("q_s_par", 256'(q.s_par), 256'b0101);
`endif
    q.out_ready = 1'b1;
    tick();
    chk("q_ov_drop", 256'(q.out_valid), 256'd0);

    // Single-chunk instance: COPY lasts one cycle
    u.a = 8'h07; u.in_valid = 1'b1; u.out_ready = 1'b0;
    tick();
    u.in_valid = 1'b0;
    chk("u_busy", 256'(u.busy), 256'd1);
    chk("u_idx", 256'(u.chunk_idx), 256'd0);
    tick();
    chk("u_ov", 256'(u.out_valid), 256'd1);
    chk("u_s", 256'(u.s), 256'h07);
    chk("u_idx_done", 256'(u.chunk_idx), 256'd0);
`ifdef CHUNK_PARITY_EN
    chk("u_s_par", 256'(u.s_par), 256'd1);
`endif

    // Asynchronous reset mid-COPY
    m.a = p1; m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_s", m.s, 256'd0);
    chk("arst_ov", 256'(m.out_valid), 256'd0);
    chk("arst_busy", 256'(m.busy), 256'd0);
    chk("arst_in_ready", 256'(m.in_ready), 256'd1);
    chk("arst_idx", 256'(m.chunk_idx), 256'd0);
    chk("arst_u_s", 256'(u.s), 256'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 256'(m.busy), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

`default_nettype wire
